// File: rtl/stage1_pkg.sv
// stage1_pkg: shared return-stack defaults and the checkpoint record type
package stage1_pkg;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_NCKPT = 4;
  localparam int VADDR_W = 48;
  typedef struct packed {
    logic [$clog2(RAS_DEPTH)-1:0] tos;
    logic [$clog2(RAS_DEPTH):0] count;
    logic [VADDR_W-1:0] top;
  } ckpt_t;
endpackage

// File: rtl/ras_ckpt_file.sv
// ras_ckpt_file: checkpoint slot storage with lowest-free-slot allocation
module ras_ckpt_file
  import stage1_pkg::*;
#(
  parameter int NCKPT = RAS_NCKPT,
  parameter type rec_t = ckpt_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     save,
  input  rec_t                     save_rec,
  input  logic                     restore,
  input  logic [$clog2(NCKPT)-1:0] restore_id,
  input  logic                     release_en,
  input  logic [$clog2(NCKPT)-1:0] release_id,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  output logic                     ckpt_full,
  output rec_t                     rec,
  output logic                     rec_valid
);
  localparam int IW = $clog2(NCKPT);
  rec_t slots [NCKPT];
  logic [NCKPT-1:0] valid, valid_n;
  logic alloc;
  assign ckpt_full = &valid;
  assign alloc = save && !ckpt_full;
  assign rec = slots[restore_id];
  assign rec_valid = valid[restore_id];
  // lowest-index free slot; set after clears so a same-slot release+save keeps it allocated
  always_comb begin
    ckpt_id = '0;
    for (int i = NCKPT - 1; i >= 0; i--) if (!valid[i]) ckpt_id = IW'(i);
    valid_n = valid;
    if (release_en) valid_n[release_id] = 1'b0;
    if (restore) valid_n[restore_id] = 1'b0;
    if (alloc) valid_n[ckpt_id] = 1'b1;
  end
  // slot allocation state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid <= '0;
    else if (flush) valid <= '0;
    else valid <= valid_n;
  end
  // slot contents are not reset; writes are abandoned while reset is asserted
  always_ff @(posedge clk) begin
    if (alloc && !reset) slots[ckpt_id] <= save_rec;
  end
endmodule

// File: rtl/spec_ras.sv
// spec_ras: circular return-address stack with speculation checkpoints
module spec_ras
  import stage1_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW = VADDR_W,
  parameter int NCKPT = RAS_NCKPT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       ckpt_save,
  output logic [$clog2(NCKPT)-1:0]   ckpt_id,
  output logic                       ckpt_full,
  input  logic                       restore,
  input  logic [$clog2(NCKPT)-1:0]   restore_id,
  input  logic                       release_en,
  input  logic [$clog2(NCKPT)-1:0]   release_id,
  output logic [AW-1:0]              top_addr,
  output logic                       top_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow
);
  localparam int TW = $clog2(DEPTH);
  localparam int CW = TW + 1;
  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  typedef struct packed {
    logic [TW-1:0] tos;
    logic [CW-1:0] count;
    logic [AW-1:0] top;
  } rec_t;
  logic [AW-1:0] mem [DEPTH];
  logic [TW-1:0] tos, tos_n, waddr;
  logic [CW-1:0] count_n;
  logic [AW-1:0] wdata, save_top;
  logic we, restoring, rec_valid, underflow_n, empty, full_s;
  rec_t rec, save_rec;
  assign empty = count == '0;
  assign full_s = count == CW'(DEPTH);
  assign top_addr = mem[tos - T1];
  assign top_valid = !empty;
  assign restoring = restore && rec_valid && !flush;
  assign save_rec = {tos_n, count_n, save_top};
  // next stack state with priority flush > restore > push/pop
  always_comb begin
    tos_n = tos;
    count_n = count;
    we = 1'b0;
    waddr = tos;
    wdata = push_addr;
    underflow_n = 1'b0;
    if (flush) begin
      tos_n = '0;
      count_n = '0;
    end else if (restoring) begin
      tos_n = rec.tos;
      count_n = rec.count;
      we = rec.count != '0;
      waddr = rec.tos - T1;
      wdata = rec.top;
    end else if (push && pop && !empty) begin
      we = 1'b1;
      waddr = tos - T1;
    end else if (push) begin
      we = 1'b1;
      tos_n = tos + T1;
      count_n = full_s ? count : count + C1;
    end else if (pop) begin
      underflow_n = empty;
      tos_n = empty ? tos : tos - T1;
      count_n = empty ? count : count - C1;
    end
    save_top = restoring ? rec.top : push ? push_addr : mem[tos_n - T1];
  end
  // stack pointer, occupancy and underflow pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos <= '0;
      count <= '0;
      underflow <= 1'b0;
    end else begin
      tos <= tos_n;
      count <= count_n;
      underflow <= underflow_n;
    end
  end
  // entry storage is not reset; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end
  ras_ckpt_file #(.NCKPT(NCKPT), .rec_t(rec_t)) u_ckpt (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .save(ckpt_save && !flush),
    .save_rec(save_rec),
    .restore(restoring),
    .restore_id(restore_id),
    .release_en(release_en),
    .release_id(release_id),
    .ckpt_id(ckpt_id),
    .ckpt_full(ckpt_full),
    .rec(rec),
    .rec_valid(rec_valid)
  );
endmodule

// File: tb/tb_spec_ras.sv
// tb_spec_ras: directed and randomized checks of spec_ras against a behavioural stack model
module tb_spec_ras;
  localparam int D = 16;
  localparam int AW = 48;
  localparam int N = 4;
  logic clk = 0, reset = 1, push = 0, pop = 0, flush = 0, ckpt_save = 0, restore = 0, release_en = 0;
  logic [AW-1:0] push_addr = '0;
  logic [1:0] restore_id = '0, release_id = '0;
  logic [1:0] ckpt_id;
  logic ckpt_full, top_valid, underflow;
  logic [AW-1:0] top_addr;
  logic [4:0] count;
  int total = 0, bad = 0;
  bit chk_en = 0;
  int mt, mc;
  bit mu;
  logic [AW-1:0] ent [D];
  bit wr [D];
  bit mv [N];
  int st [N], sc [N];
  logic [AW-1:0] stp [N];

  always #5 clk = ~clk;

  spec_ras dut (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop), .flush(flush),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .restore(restore),
    .restore_id(restore_id), .release_en(release_en), .release_id(release_id),
    .top_addr(top_addr), .top_valid(top_valid), .count(count), .underflow(underflow)
  );

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  function automatic int below(int t);
    return (t + D - 1) % D;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    mt = 0; mc = 0; mu = 0;
    foreach (mv[i]) mv[i] = 0;
  endtask

  task automatic m_step();
    int id;
    id = m_free();
    mu = 0;
    if (flush) begin
      mt = 0; mc = 0;
      foreach (mv[i]) mv[i] = 0;
      return;
    end
    if (restore && mv[restore_id]) begin
      mt = st[restore_id];
      mc = sc[restore_id];
      if (mc > 0) begin
        ent[below(mt)] = stp[restore_id];
        wr[below(mt)] = 1;
      end
      mv[restore_id] = 0;
    end else if (push && pop && mc > 0) begin
      ent[below(mt)] = push_addr;
      wr[below(mt)] = 1;
    end else if (push) begin
      ent[mt] = push_addr;
      wr[mt] = 1;
      mt = (mt + 1) % D;
      mc = (mc < D) ? mc + 1 : D;
    end else if (pop) begin
      if (mc == 0) mu = 1;
      else begin
        mt = below(mt);
        mc--;
      end
    end
    if (release_en) mv[release_id] = 0;
    if (ckpt_save && id >= 0) begin
      mv[id] = 1;
      st[id] = mt;
      sc[id] = mc;
      stp[id] = ent[below(mt)];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("count", count, mc);
      chk("top_valid", top_valid, mc > 0);
      chk("underflow", underflow, mu);
      chk("ckpt_full", ckpt_full, m_free() < 0);
      if (m_free() >= 0) chk("ckpt_id", ckpt_id, m_free());
      if (mc > 0 && wr[below(mt)]) chk("top_addr", top_addr, ent[below(mt)]);
    end
  end

  task automatic cyc(logic pu, logic po, logic [AW-1:0] a, logic fl, logic sv, logic rs,
                     logic [1:0] ri, logic rl, logic [1:0] li);
    push = pu; pop = po; push_addr = a; flush = fl; ckpt_save = sv;
    restore = rs; restore_id = ri; release_en = rl; release_id = li;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic ps(logic [AW-1:0] a); cyc(1, 0, a, 0, 0, 0, 0, 0, 0); endtask
  task automatic pp(); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic fl(); cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); endtask

  initial begin
    logic [AW-1:0] a;
    foreach (wr[i]) wr[i] = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk_en = 1;
    chk("rst_count", count, 0);
    chk("rst_valid", top_valid, 0);
    chk("rst_id", ckpt_id, 0);
    chk("rst_full", ckpt_full, 0);
    chk("rst_uf", underflow, 0);

    ps('h100); ps('h200); ps('h300);
    chk("basic_count", count, 3);
    chk("basic_top", top_addr, 'h300);
    pp();
    chk("basic_pop_top", top_addr, 'h200);
    chk("basic_pop_count", count, 2);

    fl();
    for (int i = 1; i <= 17; i++) ps(AW'(i));
    chk("wrap_count", count, 16);
    chk("wrap_top", top_addr, 17);
    for (int i = 0; i < 16; i++) begin
      pp();
      if (i == 14) chk("wrap_last_top", top_addr, 2);
    end
    chk("wrap_empty", count, 0);
    pp();
    chk("uf_pulse", underflow, 1);
    chk("uf_count", count, 0);
    idle();
    chk("uf_clear", underflow, 0);

    fl();
    ps('hA);
    cyc(1, 1, 'hB, 0, 0, 0, 0, 0, 0);
    chk("pushpop_count", count, 1);
    chk("pushpop_top", top_addr, 'hB);

    fl();
    chk("ck_first_id", ckpt_id, 0);
    cyc(1, 0, 'h10, 0, 1, 0, 0, 0, 0);
    pp(); ps('h99); ps('h98);
    chk("ck_pre_count", count, 2);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("ck_rest_count", count, 1);
    chk("ck_rest_top", top_addr, 'h10);
    chk("ck_rest_full", ckpt_full, 0);

    fl();
    repeat (4) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("full_set", ckpt_full, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("full_hold", ckpt_full, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 2);
    chk("rel_id", ckpt_id, 2);
    chk("rel_full", ckpt_full, 0);

    fl();
    ps(1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    ps(2);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("flres_count", count, 0);
    chk("flres_full", ckpt_full, 0);
    chk("flres_id", ckpt_id, 0);
    ps(5);
    ps(6);
    push_addr = 7;
    #2 reset = 1;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", top_valid, 0);
    chk("async_id", ckpt_id, 0);
    m_reset();
    @(posedge clk);
    #1;
    push = 0;
    reset = 0;
    chk("async_after", count, 0);

    repeat (3000) begin
      a = {16'($urandom()), $urandom()};
      cyc($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 40, a,
          $urandom_range(0, 63) == 0, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 10, 2'($urandom()),
          $urandom_range(0, 99) < 10, 2'($urandom()));
    end
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spec_ras.md
SPEC_RAS -- requirements
Module: spec_ras

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of stack entries (power of 2, >=4).
REQ-002 SHALL have parameter AW, default 48, meaning return-address width.
REQ-003 SHALL have parameter NCKPT, default 4, meaning number of speculation checkpoints (>=2).
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have ports push in 1 and push_addr in AW, meaning push the return address onto the stack.
REQ-007 SHALL have port pop  in  1  meaning pop the top entry.
REQ-008 SHALL have port flush  in  1  meaning empty the stack and free all checkpoints.
REQ-009 SHALL have ports ckpt_save in 1 and ckpt_id out clog2(NCKPT), meaning save a checkpoint; ckpt_id is the slot that will be allocated.
REQ-010 SHALL have port ckpt_full  out  1  meaning no free checkpoint slot.
REQ-011 SHALL have ports restore in 1 and restore_id in clog2(NCKPT), meaning repair the stack from the named checkpoint.
REQ-012 SHALL have ports release in 1 and release_id in clog2(NCKPT), meaning free the named checkpoint without repair.
REQ-013 SHALL have ports top_addr out AW and top_valid out 1, meaning the current top entry and whether count>0.
REQ-014 SHALL have ports count out clog2(DEPTH)+1 and underflow out 1; underflow is a one-cycle pulse.

Function
REQ-015 top_addr, top_valid and count SHALL be combinational from registered state (zero-cycle read); top_addr = entry[tos-1].
REQ-016 Per-cycle priority SHALL be flush > restore > push/pop; lower-priority stack operations in that cycle are ignored.
REQ-017 Push alone SHALL write entry[tos], tos+1 mod DEPTH, and count+1 saturating at DEPTH.
REQ-018 Push at count==DEPTH SHALL overwrite the oldest entry (circular wrap) with count held at DEPTH.
REQ-019 Pop alone with count>0 SHALL set tos-1 mod DEPTH and count-1.
REQ-020 Pop at count==0 SHALL leave state unchanged and pulse underflow in the next cycle.
REQ-021 Push and pop together SHALL overwrite entry[tos-1] with push_addr, leaving tos and count unchanged; at count==0 this SHALL behave as push alone.
REQ-022 ckpt_id SHALL be the lowest-index free slot; ckpt_full SHALL be high when all NCKPT slots are allocated.
REQ-023 ckpt_save with ckpt_full low SHALL allocate slot ckpt_id and store tos, count and the top entry value as they will be after this cycle's push/pop.
REQ-024 ckpt_save with ckpt_full high SHALL be ignored.
REQ-025 restore of an allocated slot SHALL, at the next edge, reload tos and count and rewrite entry[tos-1] with the saved top value when saved count>0; it SHALL also free that slot.
REQ-026 restore or release of a free slot SHALL be ignored.
REQ-027 release SHALL free the slot; a release and a save naming the same slot in one cycle SHALL leave the slot allocated with the new contents.
REQ-028 flush SHALL set tos=0 and count=0, free all slots, and clear underflow; entry contents are don't-care.
REQ-029 A restore and a save in the same cycle SHALL be permitted; the save SHALL capture the post-restore state.

Reset
REQ-030 Assertion of reset SHALL immediately force tos=0, count=0, underflow=0, all checkpoint slots free, top_valid=0 and ckpt_id=0.
REQ-031 Stack entry storage SHALL NOT be reset; top_addr is don't-care while top_valid=0.
REQ-032 Reset mid-operation SHALL abandon any push, pop or checkpoint action in that cycle.

Structure
REQ-033 A shared stage1 package SHALL hold the default RAS_DEPTH, RAS_NCKPT and VADDR_W constants and the checkpoint record typedef (tos, count, top value).
REQ-034 Checkpoint storage and free-slot allocation SHALL live in one sub-module, ras_ckpt_file; stack pointer logic and array storage SHALL stay in spec_ras.

Verification
REQ-035 Reset, then push 0x100, 0x200, 0x300 -> count=3, top_addr=0x300; one pop -> top_addr=0x200, count=2.
REQ-036 DEPTH=16: push 17 addresses 1..17 -> count=16, top_addr=17; 16 pops -> last top seen is 2; a 17th pop -> underflow pulse and count=0.
REQ-037 Push 0xA, then push+pop together with 0xB -> count=1, top_addr=0xB.
REQ-038 Push 0x10 and save (id 0); then pop, push 0x99, push 0x98; restore id 0 -> count=1, top_addr=0x10, ckpt_full=0.
REQ-039 Save NCKPT times -> ckpt_full=1; a further save is ignored; release id 2 -> ckpt_id=2, ckpt_full=0.
REQ-040 Flush and restore asserted together -> count=0, all slots free; reset asserted mid-push -> count=0 immediately, without waiting for a clock edge.
